oam_dma_arbiter: RTL and testbench

OAM DMA controller and system-bus arbiter between the CPU bus master and the memory/peripheral fabric. Owns the DMA register at 0xFF46. A CPU write to it copies 160 bytes from `{src,8'h00}` to OAM 0xFE00–0xFE9F, one byte per machine cycle. While a transfer runs, the block grants the fabric to DMA and restricts the CPU to 0xFF00–0xFFFF.

---
 rtl/oam_dma_arbiter.sv | 141 ++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// OAM DMA controller and CPU/DMA arbiter for the system fabric.
// Owns the DMA register; copies DMA_LEN bytes from {src,8'h00} into OAM.
module oam_dma_arbiter #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t      state;
  logic [7:0]  src_hi;
  logic [7:0]  idx;
  logic [1:0]  phase;
  logic [7:0]  dma_buf;
  logic        prev_wr;
  logic [15:0] hold_addr;
  logic [7:0]  hold_wdata;

  logic        is_reg;
  logic        high_io;
  logic        trigger;
  logic [7:0]  eff_src;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;

  assign is_reg  = (cpu_addr == DMA_REG_ADDR);
  assign high_io = (cpu_addr >= 16'hFF00);
  // Only the first clk of a CPU write counts; the second write clk is ignored.
  assign trigger = cpu_write_en & ~prev_wr & is_reg;
  // Echo RAM mapping: sources above DFxx fold back by 0x2000.
  assign eff_src = (src_hi <= 8'hDF) ? src_hi : (src_hi - 8'h20);
  assign rd_addr = {eff_src, idx};
  assign wr_addr = OAM_BASE + {8'h00, idx};

  assign dma_active = (state != IDLE);
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_hi     <= 8'hFF;
      idx        <= 8'h00;
      phase      <= 2'd0;
      dma_buf    <= 8'h00;
      prev_wr    <= 1'b0;
      hold_addr  <= 16'h0000;
      hold_wdata <= 8'h00;
    end else begin
      prev_wr <= cpu_write_en;
      if (trigger) begin
        // A trigger in any state restarts and discards the in-flight byte.
        src_hi <= cpu_wdata;
        idx    <= 8'h00;
        phase  <= 2'd0;
        state  <= START;
      end else begin
        case (state)
          START: begin
            if (phase == 2'd3) begin
              phase <= 2'd0;
              state <= ACTIVE;
            end else begin
              phase <= phase + 2'd1;
            end
          end
          ACTIVE: begin
            phase <= phase + 2'd1;
            case (phase)
              2'd0: hold_addr <= rd_addr;
              2'd1: begin
                hold_addr <= rd_addr;
                dma_buf   <= mem_rdata;
              end
              2'd2: begin
                hold_addr  <= wr_addr;
                hold_wdata <= dma_buf;
              end
              default: begin
                if (idx == LAST_IDX) state <= IDLE;
                else                 idx   <= idx + 8'd1;
              end
            endcase
          end
          default: phase <= 2'd0;
        endcase
      end
    end
  end

  always_comb begin
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_read_en  = cpu_read_en & ~is_reg;
    mem_write_en = cpu_write_en & ~is_reg;
    cpu_rdata    = mem_rdata;
    if (state == ACTIVE) begin
      // Fabric belongs to DMA; the address bus holds its last DMA value when idle.
      mem_addr     = hold_addr;
      mem_wdata    = hold_wdata;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      case (phase)
        2'd0, 2'd1: begin
          mem_addr    = rd_addr;
          mem_read_en = 1'b1;
        end
        2'd2: begin
          mem_addr     = wr_addr;
          mem_wdata    = dma_buf;
          mem_write_en = 1'b1;
        end
        default: ;
      endcase
      if (!high_io) cpu_rdata = 8'hFF;
    end
    if (is_reg) cpu_rdata = src_hi;
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized self-checking bench for oam_dma_arbiter with a byte-array memory
// and an expected-transaction scoreboard derived from the transfer rules.
module tb_oam_dma_arbiter;

  localparam logic [15:0] OAM = 16'hFE00;
  localparam logic [15:0] REG = 16'hFF46;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read_en;
  logic        cpu_write_en;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  wire  [7:0]  mem_rdata;
  logic        dma_active;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  oam_dma_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata),
    .dma_active(dma_active), .fsm_state(fsm_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fabric memory: registered read data, plus a side path for FFxx when the
  // fabric read strobe is idle (IO/HRAM decode the CPU bus themselves).
  logic [7:0]  mem [0:65535];
  logic [7:0]  model [0:65535];
  logic [7:0]  fab_q;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write_en) mem[mem_addr] <= mem_wdata;
    if (mem_read_en) fab_q <= mem[mem_addr];
  end
  assign mem_rdata = (cpu_read_en && cpu_addr >= 16'hFF00 && !mem_read_en) ? mem[cpu_addr] : fab_q;

  function automatic logic [7:0] eff_page(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  // Scoreboard: expected DMA reads and writes in order.
  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  bit          mon_en = 1'b0;
  int          wr_cnt = 0;
  int          trig_cyc = 0;
  int          fall_cyc = 0;
  bit          act_prev = 1'b0;

  always @(negedge clk) begin
    if (act_prev && !dma_active) fall_cyc = cyc;
    act_prev = dma_active;
    if (!reset) begin
      if (mem_read_en && mem_write_en) check("rw_overlap", 1, 0);
      if (mon_en && dma_active) begin
        if (mem_write_en) begin
          wr_cnt++;
          if (exp_wr_q.size() == 0) check("wr_extra", 1, 0);
          else check("dma_wr", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
        end
        if (mem_read_en) begin
          if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
          else check("dma_rd", mem_addr, exp_rd_q.pop_front());
        end
      end
    end
  end

  // Driver tasks.
  task automatic load_byte(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    model[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic load_page(input logic [7:0] page, input bit rnd);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = {page, 8'(i)};
      bd_data = rnd ? 8'($urandom_range(0, 255)) : (8'(i) ^ 8'h5A);
      model[bd_addr] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic build_expect(input logic [7:0] page);
    logic [7:0] e;
    e = eff_page(page);
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < 160; i++) begin
      exp_rd_q.push_back({e, 8'(i)});
      exp_rd_q.push_back({e, 8'(i)});
      exp_wr_q.push_back({OAM + 16'(i), model[{e, 8'(i)}]});
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_write_en = 1'b1;
    @(negedge clk);
    trig_cyc = cyc;
    @(negedge clk);
    cpu_write_en = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] v);
    @(negedge clk);
    cpu_addr = a; cpu_read_en = 1'b1;
    @(negedge clk);
    v = cpu_rdata;
    cpu_read_en = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input int from_cyc, input string tag);
    int n;
    n = 0;
    while (dma_active && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, dma_active, 0);
    @(negedge clk);
    check({tag, "_len"}, fall_cyc - from_cyc, 644);
  endtask

  task automatic check_oam(input logic [7:0] page);
    logic [7:0] e;
    e = eff_page(page);
    for (int i = 0; i < 160; i++) check("oam", mem[OAM + 16'(i)], model[{e, 8'(i)}]);
  endtask

  task automatic run_scored(input logic [7:0] page);
    load_page(eff_page(page), 1'b1);
    build_expect(page);
    wr_cnt = 0;
    mon_en = 1'b1;
    cpu_write(REG, page);
    wait_idle(trig_cyc, "rnd");
    mon_en = 1'b0;
    check("rnd_wr_cnt", wr_cnt, 160);
    check("rnd_q_empty", exp_wr_q.size() + exp_rd_q.size(), 0);
    check_oam(page);
  endtask

  logic [7:0] v;
  logic [7:0] hram_val;
  int t1;
  int t2;
  int n;

  initial begin
    reset = 1'b1;
    cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    cpu_read_en = 1'b0; cpu_write_en = 1'b0;
    bd_we = 1'b0; bd_addr = 16'h0000; bd_data = 8'h00;
    fab_q = 8'h00;

    // Reset state: idle pass-through, FF46 returns its reset value.
    repeat (3) @(negedge clk);
    check("rst_active", dma_active, 0);
    cpu_addr = 16'h1234; cpu_read_en = 1'b1;
    #1;
    check("rst_pass_addr", mem_addr, 16'h1234);
    check("rst_pass_rd", mem_read_en, 1);
    cpu_addr = REG;
    #1;
    check("rst_reg_rdata", cpu_rdata, 8'hFF);
    check("rst_reg_nofwd", mem_read_en, 0);
    cpu_read_en = 1'b0; cpu_addr = 16'h0000;
    @(negedge clk);
    reset = 1'b0;

    // Basic transfer from C0 with CPU probes while ACTIVE.
    load_page(8'hC0, 1'b0);
    hram_val = 8'($urandom_range(0, 255));
    load_byte(16'hFF80, hram_val);
    load_byte(16'h8000, 8'h11);
    build_expect(8'hC0);
    wr_cnt = 0;
    mon_en = 1'b1;
    cpu_write(REG, 8'hC0);
    t1 = trig_cyc;
    repeat (10) @(negedge clk);
    cpu_addr = 16'hC010; cpu_read_en = 1'b1;
    #1;
    check("act_rd_blocked", cpu_rdata, 8'hFF);
    @(negedge clk);
    check("act_rd_blocked2", cpu_rdata, 8'hFF);
    cpu_read_en = 1'b0;
    cpu_addr = 16'h8000; cpu_wdata = 8'h77; cpu_write_en = 1'b1;
    repeat (2) @(negedge clk);
    cpu_write_en = 1'b0;
    cpu_addr = 16'hFF80; cpu_read_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (mem_read_en && n < 8);
    check("act_hram_rd", cpu_rdata, hram_val);
    cpu_addr = REG;
    #1;
    check("act_reg_rd", cpu_rdata, 8'hC0);
    cpu_read_en = 1'b0; cpu_addr = 16'h0000;
    wait_idle(t1, "base");
    mon_en = 1'b0;
    check("base_wr_cnt", wr_cnt, 160);
    check("base_q_empty", exp_wr_q.size() + exp_rd_q.size(), 0);
    check("drop_cpu_wr", mem[16'h8000], 8'h11);
    for (int i = 0; i < 160; i++) check("oam_base", mem[OAM + 16'(i)], 8'(i) ^ 8'h5A);

    // Echo source FE reads from DE00..DE9F.
    run_scored(8'hFE);

    // Randomized source pages.
    for (int k = 0; k < 3; k++) run_scored(8'($urandom_range(0, 255)));

    // Restart mid-transfer at byte 50 with a new source.
    load_page(8'hC0, 1'b0);
    load_page(8'hD0, 1'b1);
    cpu_write(REG, 8'hC0);
    t1 = trig_cyc;
    n = 0;
    while (cyc < t1 + 204 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cpu_write(REG, 8'hD0);
    t2 = trig_cyc;
    wait_idle(t2, "restart");
    check_oam(8'hD0);

    // Reset in the middle of a transfer.
    cpu_write(REG, 8'hC0);
    t1 = trig_cyc;
    n = 0;
    while (cyc < t1 + 325 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_active", dma_active, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_active", dma_active, 0);
    check("mid_rst_rd_en", mem_read_en, 0);
    check("mid_rst_wr_en", mem_write_en, 0);
    cpu_addr = REG;
    #1;
    check("mid_rst_reg", cpu_rdata, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    cpu_read(16'hC010, v);
    check("post_rst_rd", v, 8'h10 ^ 8'h5A);
    cpu_read(REG, v);
    check("post_rst_reg", v, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
